// File: rtl/perceptron_pkg.sv
// perceptron_pkg
//   Shared definitions for the perceptron trainer slice:
//   - FSM state encoding (IDLE, ACCUM, DECIDE, UPDATE, DONE)
//   - clog2 helper used to size the weight-load index port
//   - generic signed saturating add, evaluated at SAT_MAX_W bits with the
//     clamp range chosen by the caller's destination width
package perceptron_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACCUM  = 3'd1;
    localparam logic [2:0] ST_DECIDE = 3'd2;
    localparam logic [2:0] ST_UPDATE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Widest operand the saturating adder supports.
    localparam int SAT_MAX_W = 64;

    // Ceiling log2, never less than 1 so a port built from it is at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return (result < 1) ? 1 : result;
    endfunction

    // Signed add of two SAT_MAX_W-bit operands (already sign-extended from
    // 'width' bits), clamped to the signed range of 'width' bits.
    // One guard bit above SAT_MAX_W keeps the raw sum exact.
    function automatic logic signed [SAT_MAX_W-1:0] sat_add(
        input logic signed [SAT_MAX_W-1:0] a,
        input logic signed [SAT_MAX_W-1:0] b,
        input int                          width
    );
        logic signed [SAT_MAX_W:0]   sum;
        logic signed [SAT_MAX_W:0]   max_v;
        logic signed [SAT_MAX_W:0]   min_v;
        logic signed [SAT_MAX_W-1:0] result;
        sum   = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
        max_v = (65'sd1 <<< (width - 1)) - 65'sd1;
        min_v = ~max_v;
        if (sum > max_v) begin
            result = max_v[SAT_MAX_W-1:0];
        end else if (sum < min_v) begin
            result = min_v[SAT_MAX_W-1:0];
        end else begin
            result = sum[SAT_MAX_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/perceptron_sat_add.sv
// perceptron_sat_add
//   Combinational signed saturating adder of parameterisable width.
//   Ports:
//     a_i   [WIDTH] signed operand
//     b_i   [WIDTH] signed operand
//     sum_o [WIDTH] a_i + b_i clamped to the signed WIDTH-bit range
module perceptron_sat_add
    import perceptron_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    output logic signed [WIDTH-1:0] sum_o
);

    // Operands are sign-extended into the package adder; the clamp keeps the
    // result inside WIDTH bits so the truncation is lossless.
    assign sum_o = WIDTH'(sat_add(SAT_MAX_W'(a_i), SAT_MAX_W'(b_i), WIDTH));

endmodule

// File: rtl/perceptron_trainer.sv
// perceptron_trainer
//   Serial binary perceptron: scores an N_IN-bit feature vector against
//   signed weights one feature per cycle with saturating accumulation, then
//   optionally applies the perceptron learning rule on a mispredict.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     in_valid_i/in_ready_o   sample handshake (ready only in IDLE)
//     features_i, label_i, train_en_i   sample contents
//     wload_valid_i, wload_idx_i, wload_data_i   weight/bias write (IDLE only;
//                         index N_IN addresses the bias)
//     out_valid_o/out_ready_i  result handshake
//     class_out_o, sum_out_o, mispredict_o  registered result
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int N_IN   = 16,
    parameter int W      = 8,
    parameter int ACC_W  = 12,
    parameter int LR     = 16,
    parameter int INIT_W = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [N_IN-1:0]             features_i,
    input  logic                        label_i,
    input  logic                        train_en_i,
    input  logic                        wload_valid_i,
    input  logic [clog2(N_IN+1)-1:0]    wload_idx_i,
    input  logic signed [W-1:0]         wload_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic                        class_out_o,
    output logic signed [ACC_W-1:0]     sum_out_o,
    output logic                        mispredict_o
);

    localparam int IDX_W = clog2(N_IN + 1);

    logic [2:0]              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [N_IN-1:0]         feat_q, feat_d;
    logic                    label_q, label_d;
    logic                    train_q, train_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [W-1:0]     weights_q [N_IN];
    logic signed [W-1:0]     weights_d [N_IN];
    logic signed [W-1:0]     bias_q, bias_d;
    logic                    class_q, class_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic                    mis_q, mis_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ready_q;

    logic                    feat_bit_s;
    logic signed [W-1:0]     w_sel_s;
    logic signed [ACC_W-1:0] w_ext_s;
    logic signed [ACC_W-1:0] acc_sum_s;
    logic signed [W-1:0]     lr_s;
    logic signed [W-1:0]     delta_s;
    logic signed [W-1:0]     upd_src_s;
    logic signed [W-1:0]     upd_sum_s;

    // Select the current feature bit and weight; idx may reach N_IN, which
    // selects nothing here (the bias is picked separately for the update).
    always_comb begin
        feat_bit_s = 1'b0;
        w_sel_s    = {W{1'b0}};
        for (int i = 0; i < N_IN; i++) begin
            feat_bit_s = (idx_q == IDX_W'(i)) ? feat_q[i]    : feat_bit_s;
            w_sel_s    = (idx_q == IDX_W'(i)) ? weights_q[i] : w_sel_s;
        end
    end

    assign w_ext_s   = ACC_W'(w_sel_s);
    assign lr_s      = W'(LR);
    assign delta_s   = label_q ? lr_s : -lr_s;
    assign upd_src_s = (idx_q == IDX_W'(N_IN)) ? bias_q : w_sel_s;

    perceptron_sat_add #(.WIDTH(ACC_W)) u_acc_add (
        .a_i   (acc_q),
        .b_i   (w_ext_s),
        .sum_o (acc_sum_s)
    );

    perceptron_sat_add #(.WIDTH(W)) u_upd_add (
        .a_i   (upd_src_s),
        .b_i   (delta_s),
        .sum_o (upd_sum_s)
    );

    // Next-state logic for the FSM, datapath and weight store.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        feat_d      = feat_q;
        label_d     = label_q;
        train_d     = train_q;
        acc_d       = acc_q;
        weights_d   = weights_q;
        bias_d      = bias_q;
        class_d     = class_q;
        sum_d       = sum_q;
        mis_d       = mis_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    // Sample starts from the bias as it stood before any
                    // coincident load.
                    feat_d  = features_i;
                    label_d = label_i;
                    train_d = train_en_i;
                    acc_d   = ACC_W'(bias_q);
                    idx_d   = {IDX_W{1'b0}};
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
                if (wload_valid_i) begin
                    if (wload_idx_i == IDX_W'(N_IN)) begin
                        bias_d = wload_data_i;
                    end else begin
                        for (int i = 0; i < N_IN; i++) begin
                            weights_d[i] = (wload_idx_i == IDX_W'(i)) ? wload_data_i : weights_d[i];
                        end
                    end
                end else begin
                    bias_d = bias_q;
                end
            end
            ST_ACCUM: begin
                if (feat_bit_s) begin
                    acc_d = acc_sum_s;
                end else begin
                    acc_d = acc_q;
                end
                if (idx_q == IDX_W'(N_IN - 1)) begin
                    idx_d   = {IDX_W{1'b0}};
                    state_d = ST_DECIDE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DECIDE: begin
                class_d = ~acc_q[ACC_W-1];
                sum_d   = acc_q;
                mis_d   = train_q & (class_d ^ label_q);
                if (mis_d) begin
                    idx_d   = {IDX_W{1'b0}};
                    state_d = ST_UPDATE;
                end else begin
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_UPDATE: begin
                if (idx_q == IDX_W'(N_IN)) begin
                    bias_d      = upd_sum_s;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    for (int i = 0; i < N_IN; i++) begin
                        weights_d[i] = ((idx_q == IDX_W'(i)) && feat_bit_s) ? upd_sum_s : weights_d[i];
                    end
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any sample in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= {IDX_W{1'b0}};
            feat_q      <= {N_IN{1'b0}};
            label_q     <= 1'b0;
            train_q     <= 1'b0;
            acc_q       <= {ACC_W{1'b0}};
            for (int i = 0; i < N_IN; i++) begin
                weights_q[i] <= W'(INIT_W);
            end
            bias_q      <= {W{1'b0}};
            class_q     <= 1'b0;
            sum_q       <= {ACC_W{1'b0}};
            mis_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            feat_q      <= feat_d;
            label_q     <= label_d;
            train_q     <= train_d;
            acc_q       <= acc_d;
            weights_q   <= weights_d;
            bias_q      <= bias_d;
            class_q     <= class_d;
            sum_q       <= sum_d;
            mis_q       <= mis_d;
            out_valid_q <= out_valid_d;
            // Registered copy of "state is IDLE".
            in_ready_q  <= (state_d == ST_IDLE);
        end
    end

    assign in_ready_o   = in_ready_q;
    assign out_valid_o  = out_valid_q;
    assign class_out_o  = class_q;
    assign sum_out_o    = sum_q;
    assign mispredict_o = mis_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// tb_perceptron_trainer
//   Directed self-checking bench for perceptron_trainer at default parameters.
module tb_perceptron_trainer;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        features;
    logic               label;
    logic               train_en;
    logic               wload_valid;
    logic [4:0]         wload_idx;
    logic signed [7:0]  wload_data;
    logic               out_valid;
    logic               out_ready;
    logic               class_out;
    logic signed [11:0] sum_out;
    logic               mispredict;

    int errors = 0;
    int checks = 0;

    perceptron_trainer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .features_i    (features),
        .label_i       (label),
        .train_en_i    (train_en),
        .wload_valid_i (wload_valid),
        .wload_idx_i   (wload_idx),
        .wload_data_i  (wload_data),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .class_out_o   (class_out),
        .sum_out_o     (sum_out),
        .mispredict_o  (mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input int data);
        wload_valid = 1'b1;
        wload_idx   = 5'(idx);
        wload_data  = 8'(data);
        tick();
        wload_valid = 1'b0;
    endtask

    // Offer a sample (DUT must be in IDLE), return the cycle number, counted
    // from the accept edge T, in which out_valid is first seen high.
    task automatic run_sample(input logic [15:0] x, input logic lbl, input logic tr,
                              output int cycle);
        int k;
        features = x;
        label    = lbl;
        train_en = tr;
        in_valid = 1'b1;
        tick();
        in_valid    = 1'b0;
        wload_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 100) begin
            tick();
            k++;
        end
        check_value("out_valid_seen", int'(out_valid), 1);
        cycle = k + 1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_value("in_ready_after_done", int'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int held_sum;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        features    = 16'h0000;
        label       = 1'b0;
        train_en    = 1'b0;
        wload_valid = 1'b0;
        wload_idx   = 5'd0;
        wload_data  = 8'sd0;
        out_ready   = 1'b0;
        repeat (3) tick();
        check_value("rst_out_valid", int'(out_valid), 0);
        check_value("rst_in_ready", int'(in_ready), 1);
        check_value("rst_sum", int'(sum_out), 0);
        check_value("rst_class", int'(class_out), 0);
        check_value("rst_mispredict", int'(mispredict), 0);
        rst_n = 1'b1;
        tick();

        // Zero weights, zero bias: score 0 classifies as 1.
        run_sample(16'hFFFF, 1'b0, 1'b0, cyc);
        check_value("t1_latency", cyc, 18);
        check_value("t1_sum", int'(sum_out), 0);
        check_value("t1_class", int'(class_out), 1);
        check_value("t1_mis", int'(mispredict), 0);
        check_value("t1_in_ready_busy", int'(in_ready), 0);
        consume();

        // Mispredict trains w[0..3] and bias down by 16.
        run_sample(16'h000F, 1'b0, 1'b1, cyc);
        check_value("t2_latency", cyc, 35);
        check_value("t2_sum", int'(sum_out), 0);
        check_value("t2_class", int'(class_out), 1);
        check_value("t2_mis", int'(mispredict), 1);
        consume();
        run_sample(16'h000F, 1'b0, 1'b0, cyc);
        check_value("t2b_sum", int'(sum_out), -80);
        check_value("t2b_class", int'(class_out), 0);
        check_value("t2b_mis", int'(mispredict), 0);
        consume();

        // All weights and bias at 127: 17*127 = 2159 clamps to 2047.
        for (int i = 0; i < 16; i++) load(i, 127);
        load(16, 127);
        run_sample(16'hFFFF, 1'b0, 1'b0, cyc);
        check_value("t3_sum_sat", int'(sum_out), 2047);
        check_value("t3_class", int'(class_out), 1);
        consume();

        // Weight update saturates at -128; bias 127 - 16 = 111.
        load(0, -120);
        load(16, 127);
        run_sample(16'h0001, 1'b0, 1'b1, cyc);
        check_value("t4_sum", int'(sum_out), 7);
        check_value("t4_mis", int'(mispredict), 1);
        consume();
        run_sample(16'h0001, 1'b0, 1'b0, cyc);
        check_value("t4b_sum", int'(sum_out), -17);
        check_value("t4b_class", int'(class_out), 0);

        // Back-pressure in DONE: outputs hold, in_valid and wload ignored.
        held_sum    = int'(sum_out);
        in_valid    = 1'b1;
        features    = 16'hFFFF;
        wload_valid = 1'b1;
        wload_idx   = 5'd16;
        wload_data  = 8'sd50;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_value("hold_out_valid", int'(out_valid), 1);
            check_value("hold_in_ready", int'(in_ready), 0);
            check_value("hold_sum", int'(sum_out), held_sum);
            check_value("hold_class", int'(class_out), 0);
        end
        in_valid    = 1'b0;
        wload_valid = 1'b0;
        consume();
        run_sample(16'h0001, 1'b0, 1'b0, cyc);
        check_value("t5_bias_unchanged", int'(sum_out), -17);
        consume();

        // Load coinciding with accept: sample sees old bias 111, next sees 100.
        wload_valid = 1'b1;
        wload_idx   = 5'd16;
        wload_data  = 8'sd100;
        run_sample(16'h0000, 1'b0, 1'b0, cyc);
        check_value("t6_preload_bias", int'(sum_out), 111);
        consume();
        run_sample(16'h0000, 1'b0, 1'b0, cyc);
        check_value("t6_postload_bias", int'(sum_out), 100);
        consume();

        // Reset in the middle of UPDATE: -128+3*127+100 = 353 -> class 1,
        // label 0 forces training; reset discards it and restores INIT_W.
        features = 16'h000F;
        label    = 1'b0;
        train_en = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        check_value("t7_busy_before_rst", int'(in_ready), 0);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_value("t7_rst_out_valid", int'(out_valid), 0);
        check_value("t7_rst_in_ready", int'(in_ready), 1);
        check_value("t7_rst_sum", int'(sum_out), 0);
        run_sample(16'hFFFF, 1'b0, 1'b0, cyc);
        check_value("t7_sum", int'(sum_out), 0);
        check_value("t7_class", int'(class_out), 1);
        check_value("t7_latency", cyc, 18);
        consume();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
